// File: rtl/fibonacci_pkg.sv
// Shared types and constants for the Fibonacci term streamer.
package fibonacci_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MODE_STOP = 0;
  localparam int unsigned MODE_WRAP = 1;

endpackage

// File: rtl/fibonacci_stream.sv
// Streams Fibonacci terms from two seeds over a valid/ready interface,
// stopping on a term count or on arithmetic overflow (or wrapping, if enabled).
module fibonacci_stream
  import fibonacci_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 8,
  parameter int unsigned WRAP  = MODE_STOP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [IDX_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             b_ovf_q, b_ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic             last_term;

  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign last_term = (cnt_q != '0) && (idx_q == cnt_q - IDX_W'(1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    b_ovf_d = b_ovf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = seed0;
          b_d     = seed1;
          b_ovf_d = 1'b0;
          idx_d   = '0;
          cnt_d   = count;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          // Reaching the requested count wins over a pending overflowed term.
          if (last_term) begin
            state_d = DONE;
          end else if (b_ovf_q && (WRAP == MODE_STOP)) begin
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            a_d     = b_q;
            b_d     = sum[WIDTH-1:0];
            b_ovf_d = sum[WIDTH];
            idx_d   = idx_q + IDX_W'(1);
            if (b_ovf_q) ovf_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      b_ovf_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      b_ovf_q <= b_ovf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign out_data  = a_q;
  assign out_index = idx_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_fibonacci_stream.sv
// Scoreboard bench: a stop-on-overflow and a wrapping instance, both 4-bit terms.
module tb_fibonacci_stream;
  import fibonacci_pkg::*;

  localparam int W  = 4;
  localparam int IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [W-1:0]  seed0, seed1;
  logic [IW-1:0] count;
  logic          start0, start1, ready0, ready1;

  logic          out_valid0, overflow0, busy0, done0;
  logic [W-1:0]  out_data0;
  logic [IW-1:0] out_index0;
  logic          out_valid1, overflow1, busy1, done1;
  logic [W-1:0]  out_data1;
  logic [IW-1:0] out_index1;

  fibonacci_stream #(.WIDTH(W), .IDX_W(IW), .WRAP(MODE_STOP)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .seed0(seed0), .seed1(seed1),
    .count(count), .out_valid(out_valid0), .out_ready(ready0), .out_data(out_data0),
    .out_index(out_index0), .overflow(overflow0), .busy(busy0), .done(done0)
  );

  fibonacci_stream #(.WIDTH(W), .IDX_W(IW), .WRAP(MODE_WRAP)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .seed0(seed0), .seed1(seed1),
    .count(count), .out_valid(out_valid1), .out_ready(ready1), .out_data(out_data1),
    .out_index(out_index1), .overflow(overflow1), .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   dn0 = 0;
  int   dn1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push0(input int d, input int i, input logic o);
    q0.push_back(exp_t'{data: W'(d), idx: IW'(i), ovf: o});
  endtask

  task automatic push1(input int d, input int i, input logic o);
    q1.push_back(exp_t'{data: W'(d), idx: IW'(i), ovf: o});
  endtask

  task automatic poll_idx(input int which, input int target, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (which == 0) found = out_valid0 && (out_index0 == IW'(target));
      else            found = out_valid1 && (out_index1 == IW'(target));
    end
    chk(name, 32'(found), 1);
  endtask

  task automatic wait_done0(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = done0;
    end
    chk(name, 32'(found), 1);
  endtask

  // dut0 monitor: pops on handshake, checks hold stability while stalled
  logic          stall0 = 1'b0;
  logic [W-1:0]  hold_d0;
  logic [IW-1:0] hold_i0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid0) begin
      if (stall0) begin
        chk("hold0 data", 32'(out_data0), 32'(hold_d0));
        chk("hold0 index", 32'(out_index0), 32'(hold_i0));
      end
      if (ready0) begin
        stall0 = 1'b0;
        if (q0.size() == 0) begin
          chk("dut0 unexpected term index", 32'(out_index0), 32'hFFFF_FFFF);
        end else begin
          e = q0.pop_front();
          chk("dut0 data", 32'(out_data0), 32'(e.data));
          chk("dut0 index", 32'(out_index0), 32'(e.idx));
          chk("dut0 overflow", 32'(overflow0), 32'(e.ovf));
        end
      end else begin
        stall0  = 1'b1;
        hold_d0 = out_data0;
        hold_i0 = out_index0;
      end
    end else begin
      stall0 = 1'b0;
    end
    if (done0) dn0++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid1 && ready1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected term index", 32'(out_index1), 32'hFFFF_FFFF);
      end else begin
        e = q1.pop_front();
        chk("dut1 data", 32'(out_data1), 32'(e.data));
        chk("dut1 index", 32'(out_index1), 32'(e.idx));
        chk("dut1 overflow", 32'(overflow1), 32'(e.ovf));
      end
    end
    if (done1) dn1++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fib_a[8]  = '{0, 1, 1, 2, 3, 5, 8, 13};
    int fib_b[11] = '{0, 1, 1, 2, 3, 5, 8, 13, 5, 2, 7};
    int dn_before;

    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    seed0 = '0; seed1 = '0; count = '0;
    #12;
    chk("rst valid0", 32'(out_valid0), 0);  chk("rst valid1", 32'(out_valid1), 0);
    chk("rst data0", 32'(out_data0), 0);    chk("rst data1", 32'(out_data1), 0);
    chk("rst index0", 32'(out_index0), 0);  chk("rst index1", 32'(out_index1), 0);
    chk("rst ovf0", 32'(overflow0), 0);     chk("rst ovf1", 32'(overflow1), 0);
    chk("rst busy0", 32'(busy0), 0);        chk("rst busy1", 32'(busy1), 0);
    chk("rst done0", 32'(done0), 0);        chk("rst done1", 32'(done1), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Stop-on-overflow run with a stall at index 5 and an ignored mid-run start
    for (int i = 0; i < 8; i++) push0(fib_a[i], i, 1'b0);
    seed0 = 4'd0; seed1 = 4'd1; count = 8'd0; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    chk("A first valid", 32'(out_valid0), 1);
    chk("A first index", 32'(out_index0), 0);
    poll_idx(0, 5, "A reach index 5");
    ready0 = 1'b0; start0 = 1'b1; seed0 = 4'd2; seed1 = 4'd3; count = 8'd3;
    @(posedge clk); #1 start0 = 1'b0;
    chk("A busy while stalled", 32'(busy0), 1);
    repeat (2) @(posedge clk);
    #1 ready0 = 1'b1;
    wait_done0("A done seen");
    chk("A overflow at done", 32'(overflow0), 1);
    chk("A no valid at done", 32'(out_valid0), 0);
    chk("A busy at done", 32'(busy0), 1);
    @(negedge clk);
    chk("A busy after done", 32'(busy0), 0);
    chk("A done one cycle", 32'(done0), 0);
    chk("A done count", 32'(dn0), 1);
    chk("A queue drained", 32'(q0.size()), 0);

    // Counted run; the accepted start also clears the sticky overflow
    @(posedge clk); #1;
    push0(2, 0, 1'b0); push0(3, 1, 1'b0); push0(5, 2, 1'b0);
    seed0 = 4'd2; seed1 = 4'd3; count = 8'd3; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    chk("C overflow cleared", 32'(overflow0), 0);
    wait_done0("C done seen");
    chk("C overflow at done", 32'(overflow0), 0);
    @(negedge clk);
    chk("C busy after done", 32'(busy0), 0);
    chk("C done count", 32'(dn0), 2);
    chk("C queue drained", 32'(q0.size()), 0);

    // Wrapping run: overflow rises with index 8, no done
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) push1(fib_b[i], i, (i >= 8));
    seed0 = 4'd0; seed1 = 4'd1; count = 8'd0; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    poll_idx(1, 10, "B reach index 10");
    @(posedge clk); #1 ready1 = 1'b0;
    chk("B continues to index 11", 32'(out_index1), 11);
    chk("B overflow sticky", 32'(overflow1), 1);
    chk("B still busy", 32'(busy1), 1);
    chk("B no done", 32'(dn1), 0);
    chk("B queue drained", 32'(q1.size()), 0);
    reset_n = 1'b0;
    #1;
    chk("B rst valid", 32'(out_valid1), 0);
    chk("B rst overflow", 32'(overflow1), 0);
    chk("B rst busy", 32'(busy1), 0);
    @(posedge clk); #1 reset_n = 1'b1; ready1 = 1'b1;

    // Reset mid-run at index 4, then restart from index 0
    for (int i = 0; i < 4; i++) push0(fib_a[i], i, 1'b0);
    seed0 = 4'd0; seed1 = 4'd1; count = 8'd0; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    poll_idx(0, 4, "D reach index 4");
    dn_before = dn0;
    reset_n = 1'b0;
    #1;
    chk("D rst valid", 32'(out_valid0), 0);
    chk("D rst data", 32'(out_data0), 0);
    chk("D rst index", 32'(out_index0), 0);
    chk("D rst busy", 32'(busy0), 0);
    chk("D rst done", 32'(done0), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("D no done after reset", 32'(dn0), 32'(dn_before));
    chk("D queue drained", 32'(q0.size()), 0);
    push0(0, 0, 1'b0); push0(1, 1, 1'b0);
    count = 8'd2; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    chk("D restart valid", 32'(out_valid0), 1);
    chk("D restart index", 32'(out_index0), 0);
    wait_done0("D restart done seen");
    @(negedge clk);
    chk("D restart done count", 32'(dn0), 32'(dn_before + 1));
    chk("D restart queue drained", 32'(q0.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
